// File: rtl/beat_scheduler_if.sv
// beat_scheduler_if: transport controls in, beat/step/tempo status out.
interface beat_scheduler_if #(
   parameter int STEPS   = 8,
   parameter int TEMPO_W = 23
);
   logic [TEMPO_W-1:0]       tempo;
   logic                     play_button;
   logic                     stop_button;
   logic                     beat_pulse;
   logic                     measure_pulse;
   logic [$clog2(STEPS)-1:0] step;
   logic                     playing;
   logic [TEMPO_W-1:0]       tempo_q;
   modport master (
      output tempo, play_button, stop_button,
      input  beat_pulse, measure_pulse, step, playing, tempo_q
   );
   modport slave (
      input  tempo, play_button, stop_button,
      output beat_pulse, measure_pulse, step, playing, tempo_q
   );
endinterface

// File: rtl/beat_scheduler.sv
// beat_scheduler: play/pause/stop transport producing beat, measure and step strobes
// from a tempo period that is latched only at beat boundaries.
module beat_scheduler #(
   parameter int                 STEPS       = 8,
   parameter int                 TEMPO_W     = 23,
   parameter logic [TEMPO_W-1:0] RESET_TEMPO = 23'd1249999
) (
   input logic             clk,
   input logic             rst,
   beat_scheduler_if.slave bus
);
   localparam int SW = $clog2(STEPS);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   state_t             state, next;
   logic [TEMPO_W-1:0] count, tempo_q;
   logic [SW-1:0]      step, step_nx;
   logic               beat, measure, wrap;
   assign wrap    = count == tempo_q;
   assign step_nx = (step == SW'(STEPS - 1)) ? '0 : step + SW'(1);
   always_ff @(posedge clk)
      state <= rst ? IDLE : next;
   always_comb begin
      next = state;
      if (bus.stop_button)
         next = IDLE;
      else if (bus.play_button)
         next = (state == RUN) ? PAUSE : RUN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         step    <= '0;
         beat    <= 1'b0;
         measure <= 1'b0;
         tempo_q <= RESET_TEMPO;
      end else if (bus.stop_button) begin
         count   <= '0;
         step    <= '0;
         beat    <= 1'b0;
         measure <= 1'b0;
      end else if (state == IDLE) begin
         count   <= '0;
         step    <= '0;
         beat    <= bus.play_button;
         measure <= bus.play_button;
         tempo_q <= bus.play_button ? bus.tempo : tempo_q;
      end else if (state == PAUSE || bus.play_button) begin
         // paused, pausing or resuming: position frozen, no strobe
         beat    <= 1'b0;
         measure <= 1'b0;
      end else if (wrap) begin
         count   <= '0;
         step    <= step_nx;
         beat    <= 1'b1;
         measure <= step_nx == '0;
         tempo_q <= bus.tempo;
      end else begin
         count   <= count + TEMPO_W'(1);
         beat    <= 1'b0;
         measure <= 1'b0;
      end
   end
   always_comb begin
      bus.beat_pulse    = beat;
      bus.measure_pulse = measure;
      bus.step          = step;
      bus.playing       = state == RUN;
      bus.tempo_q       = tempo_q;
   end
endmodule

// File: doc/beat_scheduler.md
# beat_scheduler

Transport controller for the step sequencer. It consumes the tempo period selected by the tempo selector and produces the beat strobe, step index and measure strobe that the measure counter and voice logic run from. It owns play/pause/stop sequencing. It latches a new tempo only at beat boundaries, so a tempo change never shortens or stretches a beat already in progress.

## Interface
Parameters:
- STEPS, 8: steps per measure, ≥2; step index wraps STEPS-1 → 0.
- TEMPO_W, 23: width of tempo period input and internal beat counter.
- RESET_TEMPO, 23'd1249999: value of the latched tempo after reset (240 BPM period).

Ports:
- clk  in  1  system clock.
- rst  in  1  one clock; reset is synchronous and active-high.
- tempo  in  TEMPO_W  beat period minus one, in clk cycles; sampled only at beat boundaries and on start.
- play_button  in  1  single-cycle pulse; toggles run/pause, or starts from idle.
- stop_button  in  1  single-cycle pulse; returns to idle and clears position.
- beat_pulse  out  1  one-cycle strobe at each beat.
- measure_pulse  out  1  one-cycle strobe coincident with beat_pulse when step wraps to 0.
- step  out  $clog2(STEPS)  current step index.
- playing  out  1  high in RUN only.
- tempo_q  out  TEMPO_W  currently latched beat period.

## Operation
- States: IDLE, RUN, PAUSE. All outputs registered.
- Reset (rst=1 at an edge), synchronous, overrides all inputs:
  - state=IDLE, count=0, step=0.
  - beat_pulse=0, measure_pulse=0, playing=0.
  - tempo_q=RESET_TEMPO.
  - Reset mid-RUN discards position; no pulse is emitted that cycle.
- IDLE:
  - count and step are held at 0.
  - On play_button: enter RUN with count=0, step=0, tempo_q=tempo.
  - The downbeat is emitted immediately: beat_pulse=1 and measure_pulse=1 in the first RUN cycle.
- RUN, each edge:
  - If count==tempo_q:
    - count←0.
    - step←(step==STEPS-1)?0:step+1.
    - beat_pulse←1.
    - measure_pulse←1 iff the new step==0.
    - tempo_q←tempo.
  - Otherwise count←count+1 and both pulses←0.
- PAUSE:
  - count, step and tempo_q are frozen; pulses are 0; playing=0.
  - On play_button: return to RUN and continue from the frozen count. No beat is emitted on resume; the next beat lands after the remaining tempo_q-count+1 cycles.
- play_button in RUN: enter PAUSE. count and step are frozen at their current values. Any pulse from the pausing edge is not emitted.
- stop_button in any state: IDLE with count=0, step=0, pulses 0. tempo_q is held.
- Simultaneous stop_button and play_button: stop wins.
- tempo changes mid-beat are ignored until the next boundary.
- tempo=0 is legal and gives a beat_pulse every cycle while in RUN.
- Counter arithmetic is unsigned TEMPO_W bits. count never exceeds tempo_q, so it cannot overflow.

## Timing
- Start latency: play_button sampled at edge E0 in IDLE → beat_pulse, measure_pulse and playing high in the cycle after E0.
- Beat period: tempo_q+1 clk cycles between consecutive beat_pulse rising edges. Pulse width is exactly 1 cycle.
- Measure period: STEPS×(tempo_q+1) cycles, provided tempo is constant.
- Tempo change: a new tempo presented mid-beat takes effect for the beat that begins at the next beat_pulse. tempo_q updates in that same cycle.
- Pause/resume:
  - PAUSE is entered one cycle after the play_button edge.
  - The beat phase is preserved across the pause.
  - Total RUN cycles between beats remain tempo_q+1.
- Stop: outputs are cleared in the cycle after the stop_button edge.

## Test plan
- Reset then start: rst for 2 cycles, tempo=3, STEPS=4, play pulse.
  - beat_pulse at cycles 1, 5, 9, 13, 17.
  - step 0, 1, 2, 3, 0.
  - measure_pulse at cycles 1 and 17.
- Tempo change mid-beat: running at tempo=3; set tempo=1 two cycles after a beat. The current beat still lasts 4 cycles; every following beat lasts 2 cycles; tempo_q switches in the beat_pulse cycle.
- Pause/resume: tempo=5; play pulse at count=2, wait 10 cycles, play pulse again. Step is unchanged throughout; the next beat_pulse comes 4 RUN cycles after resume; no pulses while paused.
- Stop priority: in RUN at step 2, assert play_button and stop_button together. Next cycle: IDLE, step=0, playing=0, no pulses. A later play pulse gives an immediate downbeat.
- Wrap and tempo=0: tempo=0, STEPS=4. beat_pulse every cycle; measure_pulse every 4th cycle; step cycles 0, 1, 2, 3, 0.
- Reset mid-run: assert rst while count>0 at step 3. Next cycle: IDLE, step=0, tempo_q=1249999, all pulses 0.
